// File: rtl/bpu_dyn.sv
// Fetch-stage branch predictor: pre-decodes JAL/Bxx, predicts direction (static BTFN or 2-bit PHT),
// issues a registered redirect and discards wrong-path fetch responses after a taken prediction or flush.
module bpu_dyn #(
  parameter int ADDR_W    = 32,
  parameter int PHT_ENTRY = 64,
  parameter int MODE      = 1,
  parameter int MAX_OUTST = 2,
  parameter int CNT_INIT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [31:0]       ins_i,
  input  logic              req_vld_i,
  input  logic              req_rdy_i,
  input  logic              rsp_vld_i,
  output logic              rsp_rdy_o,
  output logic              rsp_vld_o,
  input  logic              rsp_rdy_i,
  output logic              prdt_taken_o,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  input  logic              flush_i,
  input  logic              upd_vld_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i
);
  localparam int IDX_W = $clog2(PHT_ENTRY);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BXX = 7'b1100011;

  function automatic logic [1:0] sat_upd(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    else       return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

  logic                     is_jal, is_bxx, dir, pred;
  logic signed [ADDR_W-1:0] j_imm, b_imm, imm;
  logic [ADDR_W-1:0]        target;
  logic                     req_fire, rsp_fire, drop, drop_pend, taken_acc;
  logic [CNT_W-1:0]         out_cnt, out_nxt, drop_cnt;
  logic                     redirect_p1;
  logic [ADDR_W-1:0]        redirect_pc_p1;
  logic                     unused_upd;

  // p0: decode, target and direction for the response currently on the bus
  assign is_jal = (ins_i[6:0] == OP_JAL);
  assign is_bxx = (ins_i[6:0] == OP_BXX);
  assign j_imm  = {{(ADDR_W-20){ins_i[31]}}, ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
  assign b_imm  = {{(ADDR_W-12){ins_i[31]}}, ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
  assign imm    = is_jal ? j_imm : b_imm;
  assign target = pc_i + $unsigned(imm);

  generate
    if (MODE == 1) begin : g_pht
      logic [1:0]       pht [PHT_ENTRY];
      logic [IDX_W-1:0] rd_idx, wr_idx;
      assign rd_idx = pc_i[IDX_W+1:2];
      assign wr_idx = upd_pc_i[IDX_W+1:2];
      assign dir    = pht[rd_idx][1];
      assign unused_upd = ^{upd_pc_i[ADDR_W-1:IDX_W+2], upd_pc_i[1:0]};

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PHT_ENTRY; i++) pht[i] <= CNT_INIT[1:0];
        end else if (upd_vld_i) begin
          pht[wr_idx] <= sat_upd(pht[wr_idx], upd_taken_i);
        end
      end
    end else begin : g_btfn
      assign dir        = ins_i[31];
      assign unused_upd = ^{upd_vld_i, upd_taken_i, upd_pc_i};
    end
  endgenerate

  assign pred = is_jal | (is_bxx & dir);

  // Handshake passthrough; wrong-path responses are swallowed with ready held high
  assign drop_pend    = (drop_cnt != '0);
  assign drop         = flush_i | drop_pend;
  assign rsp_vld_o    = rsp_vld_i & ~drop;
  assign rsp_rdy_o    = drop ? 1'b1 : rsp_rdy_i;
  assign prdt_taken_o = rsp_vld_o & pred;

  assign req_fire  = req_vld_i & req_rdy_i;
  assign rsp_fire  = rsp_vld_i & rsp_rdy_o;
  assign taken_acc = rsp_vld_o & rsp_rdy_i & pred & ~flush_i;

  always_comb begin
    out_nxt = out_cnt;
    case ({req_fire, rsp_fire})
      2'b10:   out_nxt = out_cnt + CNT_W'(1);
      2'b01:   out_nxt = out_cnt - CNT_W'(1);
      default: out_nxt = out_cnt;
    endcase
  end

  // p1: redirect register and in-flight / drop bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt        <= '0;
      drop_cnt       <= '0;
      redirect_p1    <= 1'b0;
      redirect_pc_p1 <= '0;
    end else begin
      out_cnt     <= out_nxt;
      redirect_p1 <= taken_acc;
      if (taken_acc) redirect_pc_p1 <= target;
      if (flush_i)
        drop_cnt <= out_cnt - CNT_W'(rsp_vld_i);
      else if (taken_acc)
        drop_cnt <= out_cnt - CNT_W'(1) + CNT_W'(req_fire);
      else if (drop_pend && rsp_vld_i)
        drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  assign redirect_o    = redirect_p1;
  assign redirect_pc_o = redirect_pc_p1;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(req_fire && !rsp_fire && out_cnt == CNT_W'(MAX_OUTST)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(rsp_fire && !req_fire && out_cnt == '0));
endmodule

// File: tb/tb_bpu_dyn.sv
// Scoreboard bench for bpu_dyn: a PHT instance and a static-BTFN instance share one stimulus stream.
module tb_bpu_dyn;
  localparam logic [31:0] JAL16   = 32'h0100_006F;
  localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;
  localparam logic [31:0] BEQ_P8  = 32'h0000_0463;
  localparam logic [31:0] JALR    = 32'h0000_80E7;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam bit DYN = 1'b0, STA = 1'b1;

  typedef struct packed {
    logic        dut;
    logic        vld, rdy, tkn, redir;
    logic [31:0] rpc;
    logic        pc_chk;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] pc = '0, ins = NOP, upd_pc = '0;
  logic        req_vld = 0, req_rdy = 0, rsp_vld = 0, dec_rdy = 1;
  logic        flush = 0, upd_vld = 0, upd_taken = 0;
  logic        d_rsp_rdy, d_rsp_vld, d_tkn, d_redir;
  logic        s_rsp_rdy, s_rsp_vld, s_tkn, s_redir;
  logic [31:0] d_rpc, s_rpc;
  logic        obs = 0;
  exp_t        sb[$];
  int          checks = 0, passes = 0;

  always #5 clk = ~clk;

  bpu_dyn #(.ADDR_W(32), .PHT_ENTRY(64), .MODE(1), .MAX_OUTST(3), .CNT_INIT(1)) u_dyn (
    .clk(clk), .rst(rst), .pc_i(pc), .ins_i(ins), .req_vld_i(req_vld), .req_rdy_i(req_rdy),
    .rsp_vld_i(rsp_vld), .rsp_rdy_o(d_rsp_rdy), .rsp_vld_o(d_rsp_vld), .rsp_rdy_i(dec_rdy),
    .prdt_taken_o(d_tkn), .redirect_o(d_redir), .redirect_pc_o(d_rpc), .flush_i(flush),
    .upd_vld_i(upd_vld), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken));

  bpu_dyn #(.ADDR_W(32), .PHT_ENTRY(64), .MODE(0), .MAX_OUTST(3), .CNT_INIT(1)) u_sta (
    .clk(clk), .rst(rst), .pc_i(pc), .ins_i(ins), .req_vld_i(req_vld), .req_rdy_i(req_rdy),
    .rsp_vld_i(rsp_vld), .rsp_rdy_o(s_rsp_rdy), .rsp_vld_o(s_rsp_vld), .rsp_rdy_i(dec_rdy),
    .prdt_taken_o(s_tkn), .redirect_o(s_redir), .redirect_pc_o(s_rpc), .flush_i(flush),
    .upd_vld_i(upd_vld), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else passes++;
  endtask

  // Monitor: pops one expectation per observed cycle, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (obs) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL scoreboard_underrun: got empty queue expected entry (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        if (e.dut == STA) begin
          check("sta.rsp_vld_o", {31'b0, s_rsp_vld}, {31'b0, e.vld});
          check("sta.rsp_rdy_o", {31'b0, s_rsp_rdy}, {31'b0, e.rdy});
          check("sta.prdt_taken_o", {31'b0, s_tkn}, {31'b0, e.tkn});
          check("sta.redirect_o", {31'b0, s_redir}, {31'b0, e.redir});
          if (e.pc_chk) check("sta.redirect_pc_o", s_rpc, e.rpc);
        end else begin
          check("dyn.rsp_vld_o", {31'b0, d_rsp_vld}, {31'b0, e.vld});
          check("dyn.rsp_rdy_o", {31'b0, d_rsp_rdy}, {31'b0, e.rdy});
          check("dyn.prdt_taken_o", {31'b0, d_tkn}, {31'b0, e.tkn});
          check("dyn.redirect_o", {31'b0, d_redir}, {31'b0, e.redir});
          if (e.pc_chk) check("dyn.redirect_pc_o", d_rpc, e.rpc);
        end
      end
    end
  end

  // One clock of stimulus; inputs are set by the caller, defaults restored afterwards
  task automatic cyc(input bit chk, input bit dut, input bit ev, input bit er, input bit et,
                     input bit ed, input logic [31:0] ep, input bit epc);
    exp_t e;
    obs = chk;
    if (chk) begin
      e.dut = dut; e.vld = ev; e.rdy = er; e.tkn = et; e.redir = ed; e.rpc = ep; e.pc_chk = epc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    obs = 0; rsp_vld = 0; req_vld = 0; req_rdy = 0; flush = 0; upd_vld = 0; dec_rdy = 1;
    ins = NOP;
  endtask

  task automatic reqs(input int n);
    for (int i = 0; i < n; i++) begin
      req_vld = 1; req_rdy = 1; cyc(0, DYN, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic upd(input logic [31:0] a, input bit t, input int n);
    for (int i = 0; i < n; i++) begin
      upd_vld = 1; upd_pc = a; upd_taken = t; cyc(0, DYN, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // Response together with a new request keeps the in-flight count steady
  task automatic rsp_req(input logic [31:0] a, input logic [31:0] i);
    rsp_vld = 1; req_vld = 1; req_rdy = 1; pc = a; ins = i;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cyc(1, DYN, 0, 1, 0, 0, 32'h0, 1);          // reset state
    rst = 0;

    // JAL taken with two requests in flight
    reqs(2);
    rsp_vld = 1; pc = 32'h8000_0000; ins = JAL16;
    cyc(1, DYN, 1, 1, 1, 0, 32'h0, 1);
    rsp_vld = 1; pc = 32'h8000_0004; dec_rdy = 0;
    cyc(1, DYN, 0, 1, 0, 1, 32'h8000_0010, 1);
    rsp_req(32'h8000_0010, NOP);
    cyc(1, DYN, 1, 1, 0, 0, 32'h8000_0010, 1);

    // PHT training on a backward beq
    rsp_req(32'h100, BEQ_M8);
    cyc(1, DYN, 1, 1, 0, 0, 32'h8000_0010, 1);
    upd(32'h100, 1, 2);
    rsp_req(32'h100, BEQ_M8);
    cyc(1, DYN, 1, 1, 1, 0, 32'h8000_0010, 1);
    cyc(1, DYN, 0, 1, 0, 1, 32'hF8, 1);

    // Saturation and same-cycle read of an updating entry
    upd(32'h100, 1, 4);
    rsp_req(32'h100, BEQ_M8); upd_vld = 1; upd_pc = 32'h100; upd_taken = 0;
    cyc(1, DYN, 1, 1, 1, 0, 32'hF8, 1);
    rsp_req(32'h100, BEQ_M8);
    cyc(1, DYN, 1, 1, 1, 1, 32'hF8, 1);
    upd_vld = 1; upd_pc = 32'h100; upd_taken = 0;
    cyc(1, DYN, 0, 1, 0, 1, 32'hF8, 1);
    rsp_req(32'h100, BEQ_M8);
    cyc(1, DYN, 1, 1, 0, 0, 32'hF8, 1);
    rsp_req(32'h400, JALR);
    cyc(1, DYN, 1, 1, 0, 0, 32'hF8, 1);

    // Static BTFN instance ignores updates
    cyc(0, DYN, 0, 0, 0, 0, 0, 0);
    rsp_req(32'h204, BEQ_P8); upd_vld = 1; upd_pc = 32'h204; upd_taken = 1;
    cyc(1, STA, 1, 1, 0, 0, 32'hF8, 1);
    upd(32'h204, 1, 2);
    rsp_req(32'h204, BEQ_P8);
    cyc(1, STA, 1, 1, 0, 0, 32'hF8, 1);
    rsp_req(32'h300, BEQ_M8); upd_vld = 1; upd_pc = 32'h300; upd_taken = 0;
    cyc(1, STA, 1, 1, 1, 0, 32'hF8, 1);
    cyc(1, STA, 0, 1, 0, 1, 32'h2F8, 1);
    cyc(0, DYN, 0, 0, 0, 0, 0, 0);

    // Flush with three in flight and a response in the same cycle
    reqs(3);
    flush = 1; rsp_req(32'h8000_0000, JAL16);
    cyc(1, DYN, 0, 1, 0, 0, 32'h0, 0);
    rsp_vld = 1; pc = 32'h8000_0004; dec_rdy = 0;
    cyc(1, DYN, 0, 1, 0, 0, 32'h0, 0);
    rsp_vld = 1; pc = 32'h8000_0000; ins = JAL16;
    cyc(1, DYN, 0, 1, 0, 0, 32'h0, 0);
    rsp_vld = 1; pc = 32'h9000_0000; ins = NOP;
    cyc(1, DYN, 1, 1, 0, 0, 32'h0, 0);
    dec_rdy = 0;
    cyc(1, DYN, 0, 0, 0, 0, 32'h0, 0);

    // Reset while two wrong-path responses are still owed
    reqs(3);
    rsp_vld = 1; pc = 32'h8000_0000; ins = JAL16;
    cyc(1, DYN, 1, 1, 1, 0, 32'h0, 0);
    dec_rdy = 0;
    cyc(1, DYN, 0, 1, 0, 1, 32'h8000_0010, 1);
    rst = 1;
    cyc(0, DYN, 0, 0, 0, 0, 0, 0);
    rst = 0;
    rsp_req(32'h8000_0004, NOP);
    cyc(1, DYN, 1, 1, 0, 0, 32'h0, 1);

    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
